// File: rtl/stats_rmw_arbiter.sv
// Per-port statistics updater: buffers 12 event sources, arbitrates round-robin and
// increments table counters by read-modify-write. Optional macro: STATS_RMW_SATURATE_EN.
module stats_rmw_arbiter #(
  parameter int         PEND_W    = 3,
  parameter logic [6:0] STAT_BASE = 7'h10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  evt_rx,
  input  logic [3:0]  evt_tx,
  input  logic [3:0]  evt_er,
  input  logic        host_req,
  input  logic [6:0]  host_addr,
  input  logic [15:0] host_din,
  output logic        host_ack,
  output logic [6:0]  tbl_addr,
  output logic        tbl_wr,
  output logic [15:0] tbl_din,
  output logic [6:0]  tbl_addr_r,
  input  logic [15:0] tbl_dout,
  output logic        busy,
  output logic [11:0] ovf
);

  typedef enum logic [1:0] {IDLE = 2'd0, HOST = 2'd1, RD = 2'd2, WR = 2'd3} state_t;

  localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

  state_t             state, next_state;
  logic [PEND_W-1:0]  pend [12];
  logic [3:0]         rr_ptr, sel, next_sel;
  logic               found, grant;
  logic [11:0]        evt, grant_vec;

  function automatic logic [15:0] incr(input logic [15:0] v);
`ifdef STATS_RMW_SATURATE_EN
    return (v == 16'hFFFF) ? 16'hFFFF : v + 16'd1;
`else
    return v + 16'd1;
`endif
  endfunction

  // Source k = 3*port + type, type 0=RX 1=TX 2=ER
  always_comb begin
    evt = 12'd0;
    for (int p = 0; p < 4; p++) begin
      evt[3*p]   = evt_rx[p];
      evt[3*p+1] = evt_tx[p];
      evt[3*p+2] = evt_er[p];
    end
  end

  always_comb begin
    logic [4:0] idx;
    found    = 1'b0;
    next_sel = 4'd0;
    idx      = 5'd0;
    for (int i = 0; i < 12; i++) begin
      idx = {1'b0, rr_ptr} + 5'(i);
      if (idx >= 5'd12) idx = idx - 5'd12;
      if (!found && pend[idx[3:0]] != '0) begin
        found    = 1'b1;
        next_sel = idx[3:0];
      end
    end
  end

  always_comb begin
    next_state = state;
    grant      = 1'b0;
    case (state)
      IDLE: begin
        if (host_req) begin
          next_state = HOST;
        end else if (found) begin
          next_state = RD;
          grant      = 1'b1;
        end else begin
          next_state = IDLE;
        end
      end
      HOST:    next_state = IDLE;
      RD:      next_state = WR;
      WR:      next_state = IDLE;
      default: next_state = IDLE;
    endcase
    grant_vec = grant ? (12'd1 << next_sel) : 12'd0;
  end

  // Simultaneous event and grant cancel; an event at max is dropped and flagged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 12; k++) pend[k] <= '0;
      ovf <= 12'd0;
    end else begin
      for (int k = 0; k < 12; k++) begin
        case ({evt[k], grant_vec[k]})
          2'b10: begin
            if (pend[k] == PEND_MAX) ovf[k] <= 1'b1;
            else                     pend[k] <= pend[k] + 1'b1;
          end
          2'b01:   pend[k] <= pend[k] - 1'b1;
          default: pend[k] <= pend[k];
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      host_ack   <= 1'b0;
      tbl_wr     <= 1'b0;
      tbl_addr   <= 7'd0;
      tbl_din    <= 16'd0;
      tbl_addr_r <= 7'd0;
      sel        <= 4'd0;
      rr_ptr     <= 4'd0;
    end else begin
      state    <= next_state;
      busy     <= (next_state != IDLE);
      host_ack <= 1'b0;
      tbl_wr   <= 1'b0;
      if (grant) begin
        sel        <= next_sel;
        tbl_addr_r <= STAT_BASE + {3'd0, next_sel};
      end
      if (state == IDLE && next_state == HOST) begin
        tbl_wr   <= 1'b1;
        host_ack <= 1'b1;
        tbl_addr <= host_addr;
        tbl_din  <= host_din;
      end
      // Read data is captured straight into the write-data register for WR
      if (state == RD) begin
        tbl_wr   <= 1'b1;
        tbl_addr <= STAT_BASE + {3'd0, sel};
        tbl_din  <= incr(tbl_dout);
      end
      if (state == WR) rr_ptr <= (sel == 4'd11) ? 4'd0 : sel + 4'd1;
    end
  end

endmodule

// File: tb/tb_stats_rmw_arbiter.sv
// Scoreboard bench for stats_rmw_arbiter: a transaction-level reference predicts the
// ordered stream of table writes; a monitor pops and compares each write.
module tb_stats_rmw_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  evt_rx = 4'd0, evt_tx = 4'd0, evt_er = 4'd0;
  logic        host_req = 1'b0;
  logic [6:0]  host_addr = 7'd0;
  logic [15:0] host_din = 16'd0;
  logic        host_ack, tbl_wr, busy;
  logic [6:0]  tbl_addr, tbl_addr_r;
  logic [15:0] tbl_din, tbl_dout;
  logic [11:0] ovf;

  stats_rmw_arbiter dut (
    .clk(clk), .rst(rst), .evt_rx(evt_rx), .evt_tx(evt_tx), .evt_er(evt_er),
    .host_req(host_req), .host_addr(host_addr), .host_din(host_din), .host_ack(host_ack),
    .tbl_addr(tbl_addr), .tbl_wr(tbl_wr), .tbl_din(tbl_din), .tbl_addr_r(tbl_addr_r),
    .tbl_dout(tbl_dout), .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct { logic [6:0] addr; logic [15:0] din; logic host; } wr_t;
  typedef struct { string name; logic [31:0] act; logic [31:0] exp; } chk_t;

  wr_t   exp_q[$];
  chk_t  chk_q[$];
  int    n_vec = 0, n_err = 0, cnt_1b = 0;
  bit    hold_host = 1'b0;

  function automatic logic [15:0] init_val(input int a);
    if (a == 'h16) return 16'hFFFF;
    if (a == 'h10) return 16'h0000;
    if (a == 'h12) return 16'hFFFE;
    return 16'(a * 16'h0101);
  endfunction

  // Register table model: async read, sync write
  logic [15:0] mem [128];
  assign tbl_dout = mem[tbl_addr_r];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 128; i++) mem[i] <= init_val(i);
    end else if (tbl_wr) begin
      mem[tbl_addr] <= tbl_din;
    end
  end

  // Reference: pending counts, rotating priority, and a count of cycles the engine is occupied
  int          m_pend [12];
  int          m_ptr, m_wait;
  logic [11:0] m_ovf;
  logic [15:0] refmem [128];
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        for (int k = 0; k < 12; k++) m_pend[k] = 0;
        for (int i = 0; i < 128; i++) refmem[i] = init_val(i);
        m_ptr = 0; m_wait = 0; m_ovf = 12'd0;
        exp_q.delete();
      end else begin
        logic [11:0] ev;
        wr_t w;
        for (int p = 0; p < 4; p++) begin
          ev[3*p] = evt_rx[p]; ev[3*p+1] = evt_tx[p]; ev[3*p+2] = evt_er[p];
        end
        if (m_wait > 0) begin
          m_wait--;
        end else if (host_req) begin
          w.addr = host_addr; w.din = host_din; w.host = 1'b1;
          exp_q.push_back(w);
          refmem[host_addr] = host_din;
          m_wait = 1;
        end else begin
          for (int i = 0; i < 12; i++) begin
            int s;
            s = (m_ptr + i) % 12;
            if (m_pend[s] > 0) begin
              m_pend[s]--;
              w.addr = 7'(16 + s);
`ifdef STATS_RMW_SATURATE_EN
              w.din = (refmem[w.addr] == 16'hFFFF) ? 16'hFFFF : refmem[w.addr] + 16'd1;
`else
              w.din = refmem[w.addr] + 16'd1;
`endif
              w.host = 1'b0;
              refmem[w.addr] = w.din;
              exp_q.push_back(w);
              m_ptr = (s + 1) % 12;
              m_wait = 2;
              break;
            end
          end
        end
        for (int k = 0; k < 12; k++)
          if (ev[k]) begin
            if (m_pend[k] == 7) m_ovf[k] = 1'b1;
            else                m_pend[k]++;
          end
      end
    end
  end

  // Monitor: every comparison is made here
  initial begin
    forever begin
      @(negedge clk);
      while (chk_q.size() > 0) begin
        chk_t c;
        c = chk_q.pop_front();
        n_vec++;
        if (c.act !== c.exp) begin
          n_err++;
          $display("FAIL %s: got %h expected %h", c.name, c.act, c.exp);
        end
      end
      if (!rst && tbl_wr) begin
        n_vec++;
        if (!tbl_wr) cnt_1b = cnt_1b;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_write: got addr %h din %h expected none", tbl_addr, tbl_din);
        end else begin
          wr_t w;
          w = exp_q.pop_front();
          if (tbl_addr !== w.addr || tbl_din !== w.din || host_ack !== w.host) begin
            n_err++;
            $display("FAIL table_write: got addr %h din %h ack %b expected addr %h din %h ack %b",
                     tbl_addr, tbl_din, host_ack, w.addr, w.din, w.host);
          end
        end
        if (!host_ack && tbl_addr == 7'h1b) cnt_1b++;
      end else if (!rst && host_ack) begin
        n_vec++; n_err++;
        $display("FAIL ack_without_write: got host_ack 1 expected 0");
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] a, input logic [31:0] e);
    chk_t c;
    c.name = nm; c.act = a; c.exp = e;
    chk_q.push_back(c);
  endtask

  task automatic tick(input logic [11:0] ev);
    @(negedge clk);
    if (host_ack && !hold_host) host_req = 1'b0;
    for (int p = 0; p < 4; p++) begin
      evt_rx[p] = ev[3*p]; evt_tx[p] = ev[3*p+1]; evt_er[p] = ev[3*p+2];
    end
  endtask

  task automatic host_go(input logic [6:0] a, input logic [15:0] d);
    host_req = 1'b1; host_addr = a; host_din = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) tick(12'd0);
    rst = 1'b0;
    check("reset_outputs", {7'd0, tbl_wr, host_ack, busy, tbl_addr, tbl_addr_r}, 32'd0);
    check("reset_data", {tbl_din, 4'd0, ovf}, 32'd0);
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      int sum;
      sum = 0;
      for (int k = 0; k < 12; k++) sum += m_pend[k];
      if (exp_q.size() == 0 && !busy && sum == 0 && !host_req) done = 1'b1;
      else tick(12'd0);
    end
    check("drain_done", {31'd0, done}, 32'd1);
  endtask

  initial begin
    int bc, c0;
    do_reset();

    // Single event on source 0
    tick(12'h001);
    bc = 0;
    for (int i = 0; i < 8; i++) begin
      tick(12'd0);
      if (busy) begin
        bc++;
        if (bc == 1) check("rd_addr_r", {25'd0, tbl_addr_r}, 32'h10);
      end
    end
    check("busy_cycles", bc, 2);
    drain();

    // All sources at once from a fresh pointer
    do_reset();
    tick(12'hFFF);
    drain();

    // Starvation under held host request, with overflow of source 11
    hold_host = 1'b1;
    tick(12'd0);
    host_go(7'h05, 16'hA5A5);
    for (int i = 0; i < 9; i++) tick(12'h800);
    tick(12'd0);
    check("ovf11_set", {31'd0, ovf[11]}, 32'd1);
    c0 = cnt_1b;
    hold_host = 1'b0;
    drain();
    check("burst_incr_count", cnt_1b - c0, 7);

    // Event on grant cycle, then host request during RD of source 4
    tick(12'h010);
    tick(12'h010);
    tick(12'd0);
    host_go(7'h02, 16'h0003);
    drain();

    // Wrap/saturate on 0x16
    do_reset();
    tick(12'h040);
    drain();

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      logic [11:0] ev;
      for (int k = 0; k < 12; k++) ev[k] = ($urandom_range(0, 15) == 0);
      tick(ev);
      if (!host_req && $urandom_range(0, 9) == 0)
        host_go(($urandom_range(0, 1) != 0) ? 7'(16 + $urandom_range(0, 11)) : 7'($urandom_range(0, 15)),
                16'($urandom));
    end
    drain();
    check("ovf_final", {20'd0, ovf}, {20'd0, m_ovf});
    check("queue_empty", exp_q.size(), 0);

    for (int i = 0; i < 50 && chk_q.size() > 0; i++) tick(12'd0);
    tick(12'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
